rl_dma: RTL and testbench

Unibus NPR master that performs one DMA word transfer per ARM command for the RL01/2 disk path. It sits between the RL11 register block and the Unibus. The ARM-side disk service loads the address from the RL11 bus-address registers (RLBA plus the BA[17:16] bits of RLCS), then issues a DATI or DATO. This block arbitrates for the bus, runs the MSYN/SSYN handshake, and reports the read data or an NXM.

---
 rtl/rl_dma_pkg.sv | 28 ++
 rtl/rl_dma_if.sv | 33 +++
 rtl/rl_dma_cnt.sv | 33 +++
 rtl/rl_dma.sv | 230 +++++++++++++++++++++++
 tb/tb_rl_dma.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rl_dma_pkg.sv
// rl_dma_pkg: shared types and constants for the RL01/2 Unibus NPR DMA master.
//   state_t      - bus-cycle sequencer states
//   C_DATI/C_DATO - Unibus C[1:0] cycle codes
//   IDENT        - value returned by ARM register 0
//   REG_*        - ARM register indices
package rl_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SACK,
    ST_OWN,
    ST_MSYN,
    ST_DROP
  } state_t;

  localparam logic [1:0]  C_DATI = 2'b00;
  localparam logic [1:0]  C_DATO = 2'b10;

  // "DM", version 3
  localparam logic [31:0] IDENT  = 32'h444D1003;

  localparam logic [1:0]  REG_IDENT = 2'd0;
  localparam logic [1:0]  REG_CSR   = 2'd1;
  localparam logic [1:0]  REG_DATA  = 2'd2;
  localparam logic [1:0]  REG_CLR   = 2'd3;

endpackage

// File: rtl/rl_dma_if.sv
// rl_dma_if: Unibus-side signal bundle of the DMA master.
//   Inputs to the master : init_in_h, npg_in_h, bbsy_in_h, ssyn_in_h, d_in_h[15:0]
//   Outputs of the master: npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h,
//                          a_out_h[ADDRBITS-1:0], c_out_h[1:0], d_out_h[15:0]
//   modport master - the DMA block; modport slave - the bus / arbiter side.
interface rl_dma_if #(
  parameter int ADDRBITS = 18
) ();

  logic                init_in_h;
  logic                npg_in_h;
  logic                bbsy_in_h;
  logic                ssyn_in_h;
  logic [15:0]         d_in_h;
  logic                npr_out_h;
  logic                sack_out_h;
  logic                bbsy_out_h;
  logic                msyn_out_h;
  logic [ADDRBITS-1:0] a_out_h;
  logic [1:0]          c_out_h;
  logic [15:0]         d_out_h;

  modport master (
    input  init_in_h, npg_in_h, bbsy_in_h, ssyn_in_h, d_in_h,
    output npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, a_out_h, c_out_h, d_out_h
  );

  modport slave (
    output init_in_h, npg_in_h, bbsy_in_h, ssyn_in_h, d_in_h,
    input  npr_out_h, sack_out_h, bbsy_out_h, msyn_out_h, a_out_h, c_out_h, d_out_h
  );

endinterface

// File: rtl/rl_dma_cnt.sv
// rl_dma_cnt: loadable down-counter that stops at zero. Used for the
// DESKEW delay and for the optional SSYN timeout.
//   i_clk, i_rst_n - clock, async active-low reset
//   i_load         - load i_load_val (has priority over i_dec)
//   i_load_val     - value to load
//   i_dec          - decrement by one unless already zero
//   o_cnt          - current count
module rl_dma_cnt #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/rl_dma.sv
// rl_dma: Unibus NPR master performing one DMA word transfer (DATI/DATO)
// per ARM START command for the RL01/2 disk path.
//   CLOCK, RESET_N        - system clock, async active-low reset
//   armwrite, armwaddr,
//   armwdata              - ARM register write port
//   armraddr, armrdata    - ARM register read port (combinational read)
//   armintrq              - DONE, wakes the ARM service
//   bus (rl_dma_if.master)- Unibus request/grant, MSYN/SSYN, address/data
// Build option: define RL_DMA_NXM_TIMER_EN to build the SSYN timeout that
// ends an unanswered MSYN after TIMEOUT cycles and flags NXM. Without it
// MSYN waits for SSYN forever and NXM stays 0.
module rl_dma
  import rl_dma_pkg::*;
#(
  parameter int ADDRBITS = 18,
  parameter int DESKEW   = 8,
  parameter int TIMEOUT  = 1000
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  output logic        armintrq,
  rl_dma_if.master    bus
);

  localparam logic [7:0] DK_LOAD = 8'(DESKEW);

  state_t              r_state;
  logic                r_busy;
  logic                r_done;
  logic                r_nxm;
  logic                r_write;
  logic [ADDRBITS-1:0] r_addr;
  logic [15:0]         r_wdata;
  logic [15:0]         r_rdata;
  logic                r_npr;
  logic                r_sack;
  logic                r_bbsy;
  logic                r_msyn;
  logic [ADDRBITS-1:0] r_a;
  logic [1:0]          r_c;
  logic [15:0]         r_d;

  logic                w_start;
  logic                w_dk_load;
  logic                w_dk_dec;
  logic [7:0]          w_dk_cnt;
  logic                w_dk_last;
  logic                w_timeout;
  logic                w_unused_wdata;

  assign w_unused_wdata = ^{armwdata[29:ADDRBITS], armwdata[0]};

  // START is only honoured while idle; a START arriving while busy is dropped.
  assign w_start = armwrite && (armwaddr == REG_CSR) && armwdata[31] && !r_busy;

  // The deskew counter is reloaded while waiting (SACK, MSYN, DROP with SSYN
  // still high) so it always starts a full DESKEW run on the next state.
  assign w_dk_load = (r_state == ST_SACK) || (r_state == ST_MSYN) ||
                     ((r_state == ST_DROP) && bus.ssyn_in_h);
  assign w_dk_dec  = (r_state == ST_OWN) ||
                     ((r_state == ST_DROP) && !bus.ssyn_in_h);
  assign w_dk_last = (w_dk_cnt == 8'd1);

  rl_dma_cnt #(.W(8)) u_deskew (
    .i_clk      (CLOCK),
    .i_rst_n    (RESET_N),
    .i_load     (w_dk_load),
    .i_load_val (DK_LOAD),
    .i_dec      (w_dk_dec),
    .o_cnt      (w_dk_cnt)
  );

`ifdef RL_DMA_NXM_TIMER_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] w_to_cnt;

  // Loaded with TIMEOUT outside MSYN; the TIMEOUT-th MSYN cycle sees 1.
  rl_dma_cnt #(.W(TW)) u_timeout (
    .i_clk      (CLOCK),
    .i_rst_n    (RESET_N),
    .i_load     (r_state != ST_MSYN),
    .i_load_val (TW'(TIMEOUT)),
    .i_dec      (r_state == ST_MSYN),
    .o_cnt      (w_to_cnt)
  );

  assign w_timeout = (w_to_cnt == TW'(1));
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = TIMEOUT;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_nxm   <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_npr   <= 1'b0;
      r_sack  <= 1'b0;
      r_bbsy  <= 1'b0;
      r_msyn  <= 1'b0;
      r_a     <= '0;
      r_c     <= '0;
      r_d     <= '0;
    end else begin
      if (bus.init_in_h) begin
        // Bus INIT aborts the cycle; DONE/NXM and the data registers survive.
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
        r_npr   <= 1'b0;
        r_sack  <= 1'b0;
        r_bbsy  <= 1'b0;
        r_msyn  <= 1'b0;
        r_a     <= '0;
        r_c     <= '0;
        r_d     <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_start) begin
              r_state <= ST_REQ;
              r_busy  <= 1'b1;
              r_done  <= 1'b0;
              r_nxm   <= 1'b0;
              r_npr   <= 1'b1;
            end
          end
          ST_REQ: begin
            if (bus.npg_in_h) begin
              r_state <= ST_SACK;
              r_npr   <= 1'b0;
              r_sack  <= 1'b1;
            end
          end
          ST_SACK: begin
            // Take the bus only once the grant is gone and the previous
            // master has finished (BBSY and SSYN both clear).
            if (!bus.npg_in_h && !bus.bbsy_in_h && !bus.ssyn_in_h) begin
              r_state <= ST_OWN;
              r_sack  <= 1'b0;
              r_bbsy  <= 1'b1;
              r_a     <= r_addr;
              r_c     <= r_write ? C_DATO : C_DATI;
              r_d     <= r_write ? r_wdata : 16'h0000;
            end
          end
          ST_OWN: begin
            if (w_dk_last) begin
              r_state <= ST_MSYN;
              r_msyn  <= 1'b1;
            end
          end
          ST_MSYN: begin
            if (bus.ssyn_in_h) begin
              if (!r_write) begin
                r_rdata <= bus.d_in_h;
              end
              r_state <= ST_DROP;
              r_msyn  <= 1'b0;
            end else if (w_timeout) begin
              r_nxm   <= 1'b1;
              r_state <= ST_DROP;
              r_msyn  <= 1'b0;
            end
          end
          ST_DROP: begin
            if (!bus.ssyn_in_h && w_dk_last) begin
              r_state <= ST_IDLE;
              r_bbsy  <= 1'b0;
              r_a     <= '0;
              r_c     <= '0;
              r_d     <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end

      if (armwrite && !r_busy) begin
        if (armwaddr == REG_CSR) begin
          r_addr  <= {armwdata[ADDRBITS-1:1], 1'b0};
          r_write <= armwdata[30];
        end else if (armwaddr == REG_DATA) begin
          r_wdata <= armwdata[15:0];
        end
      end

      // Placed last so a clear coinciding with completion leaves DONE at 0.
      if (armwrite && (armwaddr == REG_CLR)) begin
        r_done <= 1'b0;
        r_nxm  <= 1'b0;
      end
    end
  end

  always_comb begin
    armrdata = 32'h0;
    case (armraddr)
      REG_IDENT: armrdata = IDENT;
      REG_CSR:   armrdata = {r_busy, r_done, r_nxm, {(29-ADDRBITS){1'b0}}, r_addr};
      REG_DATA:  armrdata = {r_rdata, r_wdata};
      default:   armrdata = 32'h0;
    endcase
  end

  assign armintrq       = r_done;
  assign bus.npr_out_h  = r_npr;
  assign bus.sack_out_h = r_sack;
  assign bus.bbsy_out_h = r_bbsy;
  assign bus.msyn_out_h = r_msyn;
  assign bus.a_out_h    = r_a;
  assign bus.c_out_h    = r_c;
  assign bus.d_out_h    = r_d;

endmodule

// File: tb/tb_rl_dma.sv
// tb_rl_dma: self-checking bench for rl_dma. Register vectors come from a
// table; bus transfers push their expected address/cycle/data onto a
// scoreboard queue that is popped when the DUT takes the bus.
module tb_rl_dma;
  import rl_dma_pkg::*;

  localparam int DESKEW  = 8;
  localparam int TIMEOUT = 1000;

  logic        CLOCK    = 1'b0;
  logic        RESET_N  = 1'b0;
  logic        armwrite = 1'b0;
  logic [1:0]  armraddr = 2'd0;
  logic [1:0]  armwaddr = 2'd0;
  logic [31:0] armwdata = 32'h0;
  logic [31:0] armrdata;
  logic        armintrq;

  rl_dma_if #(.ADDRBITS(18)) bus ();

  rl_dma #(.ADDRBITS(18), .DESKEW(DESKEW), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK    (CLOCK),
    .RESET_N  (RESET_N),
    .armwrite (armwrite),
    .armraddr (armraddr),
    .armwaddr (armwaddr),
    .armwdata (armwdata),
    .armrdata (armrdata),
    .armintrq (armintrq),
    .bus      (bus)
  );

  always #5 CLOCK = ~CLOCK;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [17:0] a;
    logic [1:0]  c;
    logic [15:0] d;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic        wr;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic arm_wr(input logic [1:0] a, input logic [31:0] d);
    armwaddr = a;
    armwdata = d;
    armwrite = 1'b1;
    @(negedge CLOCK);
    armwrite = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    armraddr = a;
    #1;
    v = armrdata;
  endtask

  function automatic logic bus_idle();
    return ({bus.npr_out_h, bus.sack_out_h, bus.bbsy_out_h, bus.msyn_out_h,
             bus.a_out_h, bus.c_out_h, bus.d_out_h} === 40'h0);
  endfunction

  // START a transfer, play arbiter, and return at the first cycle of MSYN.
  task automatic start_xfer(input logic [17:0] addr, input logic wr, input logic [15:0] wd,
                            input int bbsy_hold, input string tag);
    exp_t e;
    int   n;
    int   bad;
    if (wr) arm_wr(REG_DATA, {16'h0, wd});
    arm_wr(REG_CSR, {1'b1, wr, 12'b0, addr});
    e.a = {addr[17:1], 1'b0};
    e.c = wr ? C_DATO : C_DATI;
    e.d = wr ? wd : 16'h0;
    sb_q.push_back(e);
    chk({tag, " npr"}, {31'b0, bus.npr_out_h}, 32'd1);
    bus.npg_in_h = 1'b1;
    @(negedge CLOCK);
    chk({tag, " sack"}, {30'b0, bus.npr_out_h, bus.sack_out_h}, 32'b01);
    bus.npg_in_h  = 1'b0;
    bus.bbsy_in_h = (bbsy_hold > 0);
    if (bbsy_hold > 0) begin
      bad = 0;
      for (int i = 0; i < bbsy_hold; i++) begin
        @(negedge CLOCK);
        if (!bus.sack_out_h || bus.bbsy_out_h) bad++;
      end
      chk({tag, " sack held while bbsy"}, bad, 0);
      bus.bbsy_in_h = 1'b0;
    end
    n = 0;
    while (!bus.bbsy_out_h && n < 50) begin
      @(negedge CLOCK);
      n++;
    end
    chk({tag, " own bbsy/sack"}, {30'b0, bus.bbsy_out_h, bus.sack_out_h}, 32'b10);
    if (sb_q.size() == 0) begin
      chk({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, " addr"}, {14'b0, bus.a_out_h}, {14'b0, e.a});
      chk({tag, " c/d"}, {14'b0, bus.c_out_h, bus.d_out_h}, {14'b0, e.c, e.d});
    end
    n   = 0;
    bad = 0;
    while (!bus.msyn_out_h && n < 300) begin
      n++;
      if (bus.a_out_h !== e.a || bus.c_out_h !== e.c || bus.d_out_h !== e.d) bad++;
      @(negedge CLOCK);
    end
    chk({tag, " deskew cycles"}, n, DESKEW);
    chk({tag, " addr/data stable"}, bad, 0);
  endtask

  // Slave answers after 'delay' MSYN cycles; either waits for the bus
  // release or fires a reg 3 clear in the exact completion cycle.
  task automatic finish_ssyn(input int delay, input logic [15:0] data, input string tag,
                             input bit clr_at_done, input bit is_read);
    int          n;
    int          bad;
    logic [31:0] v;
    bad = 0;
    for (int i = 0; i < delay; i++) begin
      if (!bus.msyn_out_h) bad++;
      @(negedge CLOCK);
    end
    chk({tag, " msyn held"}, bad, 0);
    bus.ssyn_in_h = 1'b1;
    bus.d_in_h    = data;
    @(negedge CLOCK);
    chk({tag, " msyn drop"}, {30'b0, bus.msyn_out_h, bus.bbsy_out_h}, 32'b01);
    if (is_read) begin
      rd(REG_DATA, v);
      chk({tag, " rdata"}, {16'h0, v[31:16]}, {16'h0, data});
    end
    @(negedge CLOCK);
    @(negedge CLOCK);
    bus.ssyn_in_h = 1'b0;
    bus.d_in_h    = 16'h0;
    if (clr_at_done) begin
      repeat (DESKEW - 1) @(negedge CLOCK);
      armwaddr = REG_CLR;
      armwdata = 32'h0;
      armwrite = 1'b1;
      @(negedge CLOCK);
      armwrite = 1'b0;
      chk({tag, " release+clr bbsy/intrq"}, {30'b0, bus.bbsy_out_h, armintrq}, 32'b00);
    end else begin
      n = 0;
      while (bus.bbsy_out_h && n < 50) begin
        @(negedge CLOCK);
        n++;
      end
      chk({tag, " release delay"}, n, DESKEW);
      chk({tag, " bus idle"}, {31'b0, bus_idle()}, 32'd1);
      chk({tag, " intrq"}, {31'b0, armintrq}, 32'd1);
    end
  endtask

  initial begin
    logic [31:0] v;
    int          n;
    int          bad;

    bus.init_in_h = 1'b0;
    bus.npg_in_h  = 1'b0;
    bus.bbsy_in_h = 1'b0;
    bus.ssyn_in_h = 1'b0;
    bus.d_in_h    = 16'h0;

    vecs[0] = '{1'b0, 2'd0, 32'h0,         2'd0, 32'h444D1003};
    vecs[1] = '{1'b0, 2'd0, 32'h0,         2'd1, 32'h0};
    vecs[2] = '{1'b1, 2'd1, 32'h0003_FFFF, 2'd1, 32'h0003_FFFE};
    vecs[3] = '{1'b1, 2'd1, 32'h4000_1235, 2'd1, 32'h0000_1234};
    vecs[4] = '{1'b1, 2'd2, 32'hABCD_5A5A, 2'd2, 32'h0000_5A5A};
    vecs[5] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 2'd1, 32'h0000_1234};
    vecs[6] = '{1'b1, 2'd1, 32'h0000_0001, 2'd1, 32'h0};

    repeat (3) @(negedge CLOCK);
    chk("reset bus idle", {31'b0, bus_idle()}, 32'd1);
    chk("reset intrq", {31'b0, armintrq}, 32'd0);
    rd(REG_CSR, v);
    chk("reset csr", v, 32'h0);
    rd(REG_DATA, v);
    chk("reset data", v, 32'h0);
    RESET_N = 1'b1;
    @(negedge CLOCK);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].wr) arm_wr(vecs[i].waddr, vecs[i].wdata);
      else @(negedge CLOCK);
      rd(vecs[i].raddr, v);
      chk($sformatf("vec%0d", i), v, vecs[i].exp);
    end

    // DATI 774400, slave answers after 5 cycles
    start_xfer(18'o774400, 1'b0, 16'h0, 0, "dati");
    finish_ssyn(5, 16'o123456, "dati", 1'b0, 1'b1);
    rd(REG_CSR, v);
    chk("dati csr", v, {1'b0, 1'b1, 1'b0, 11'b0, 18'o774400});
    rd(REG_DATA, v);
    chk("dati data", v, {16'o123456, 16'h5A5A});

    // DATO 001000 with another master holding BBSY for 20 cycles
    start_xfer(18'o001000, 1'b1, 16'o177777, 20, "dato");
    finish_ssyn(3, 16'h1111, "dato", 1'b0, 1'b0);
    rd(REG_DATA, v);
    chk("dato data", v, {16'o123456, 16'o177777});
    rd(REG_CSR, v);
    chk("dato csr", v, {1'b0, 1'b1, 1'b0, 11'b0, 18'o001000});

    // No SSYN from the slave
    start_xfer(18'o000200, 1'b0, 16'h0, 0, "nossyn");
`ifdef RL_DMA_NXM_TIMER_EN
    n = 0;
    while (bus.msyn_out_h && n < TIMEOUT + 50) begin
      n++;
      @(negedge CLOCK);
    end
    chk("nossyn msyn cycles", n, TIMEOUT);
    n = 0;
    while (bus.bbsy_out_h && n < 50) begin
      @(negedge CLOCK);
      n++;
    end
    chk("nossyn bus idle", {31'b0, bus_idle()}, 32'd1);
    rd(REG_CSR, v);
    chk("nossyn csr flags", {29'b0, v[31:29]}, 32'b011);
`else
    repeat (TIMEOUT + 20) @(negedge CLOCK);
    chk("nossyn msyn still up", {31'b0, bus.msyn_out_h}, 32'd1);
    rd(REG_CSR, v);
    chk("nossyn busy no nxm", {29'b0, v[31:29]}, 32'b100);
    finish_ssyn(0, 16'h2468, "nossyn", 1'b0, 1'b1);
    rd(REG_CSR, v);
    chk("nossyn csr flags", {29'b0, v[31:29]}, 32'b010);
`endif

    // INIT during MSYN
    start_xfer(18'o070000, 1'b1, 16'h0F0F, 0, "init");
    repeat (2) @(negedge CLOCK);
    bus.init_in_h = 1'b1;
    @(negedge CLOCK);
    bus.init_in_h = 1'b0;
    chk("init bus idle", {31'b0, bus_idle()}, 32'd1);
    rd(REG_CSR, v);
    chk("init csr", v, {1'b0, 1'b0, 1'b0, 11'b0, 18'o070000});
    rd(REG_DATA, v);
    chk("init wdata", {16'h0, v[15:0]}, 32'h0000_0F0F);
    repeat (3) @(negedge CLOCK);
    chk("init stays idle", {31'b0, bus_idle()}, 32'd1);

    // Second START while busy, reg 3 clear coinciding with DONE
    start_xfer(18'o000400, 1'b1, 16'hBEEF, 0, "dbl");
    arm_wr(REG_CSR, {1'b1, 1'b0, 12'b0, 18'o002000});
    arm_wr(REG_DATA, 32'h0000_1234);
    finish_ssyn(1, 16'h0, "dbl", 1'b1, 1'b0);
    rd(REG_CSR, v);
    chk("dbl csr", v, {1'b0, 1'b0, 1'b0, 11'b0, 18'o000400});
    rd(REG_DATA, v);
    chk("dbl wdata", {16'h0, v[15:0]}, 32'h0000_BEEF);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK);
      if (bus.npr_out_h) bad++;
    end
    chk("dbl no queued start", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
